// File: rtl/pcler8_snap_reader.sv
// Loadable up-counter with carry chain plus a snapshot reader that serialises the counter value.
// Optional macro PCLER8_SNAP_PARITY_EN appends an even-parity bit to every frame.
module pcler8_snap_reader #(
    parameter int CNT_W     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk_pad,
    input  logic             rst_pad,
    input  logic [CNT_W-1:0] d_pad,
    input  logic             ld_pad,
    input  logic             clr_pad,
    input  logic             en_pad,
    input  logic             cin_pad,
    output logic [CNT_W-1:0] cnt_pad,
    output logic             cout_pad,
    input  logic             snap_req_pad,
    output logic             snap_ack_pad,
    output logic             sdo_pad,
    output logic             sdo_vld_pad,
    input  logic             sdo_rdy_pad,
    output logic             busy_pad
);

`ifdef PCLER8_SNAP_PARITY_EN
    localparam int N = CNT_W + 1;
`else
    localparam int N = CNT_W;
`endif
    localparam int IDX_W = $clog2(N + 1);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] sreg;
    logic [IDX_W-1:0] idx;
    logic             data_bit;
    logic             cur_bit;
    logic             count_up;
    logic             accept;

    assign count_up = en_pad & cin_pad;
    assign accept   = (state == IDLE) & snap_req_pad;

    always_ff @(posedge clk_pad or posedge rst_pad) begin
        if (rst_pad) begin
            cnt_pad <= '0;
        end else if (ld_pad) begin
            cnt_pad <= d_pad;
        end else if (clr_pad) begin
            cnt_pad <= '0;
        end else if (count_up) begin
            cnt_pad <= cnt_pad + 1'b1;
        end
    end

    assign cout_pad = count_up & ~ld_pad & ~clr_pad & (&cnt_pad);

    // The snapshot shifts toward the output end so the current bit always sits at a fixed position.
    always_ff @(posedge clk_pad or posedge rst_pad) begin
        if (rst_pad) begin
            state <= IDLE;
            sreg  <= '0;
            idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (snap_req_pad) begin
                        state <= SHIFT;
                        sreg  <= cnt_pad;
                        idx   <= '0;
                    end
                end
                SHIFT: begin
                    if (sdo_rdy_pad) begin
                        idx  <= idx + 1'b1;
                        sreg <= (MSB_FIRST != 0) ? (sreg << 1) : (sreg >> 1);
                        if (idx == LAST) begin
                            state <= DONE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign data_bit = (MSB_FIRST != 0) ? sreg[CNT_W-1] : sreg[0];

`ifdef PCLER8_SNAP_PARITY_EN
    logic par;

    // Parity is taken from the same pre-update value the shift register captures.
    always_ff @(posedge clk_pad or posedge rst_pad) begin
        if (rst_pad) begin
            par <= 1'b0;
        end else if (accept) begin
            par <= ^cnt_pad;
        end
    end

    assign cur_bit = (idx == IDX_W'(CNT_W)) ? par : data_bit;
`else
    assign cur_bit = data_bit | (accept & 1'b0);
`endif

    assign sdo_vld_pad  = (state == SHIFT);
    assign sdo_pad      = sdo_vld_pad & cur_bit;
    assign snap_ack_pad = (state == DONE);
    assign busy_pad     = (state != IDLE);

endmodule

// File: tb/tb_pcler8_snap_reader.sv
// Self-checking bench for pcler8_snap_reader: directed scenarios followed by random traffic,
// all compared against a queue-based model of the counter and the serial frame.
module tb_pcler8_snap_reader;

    localparam int W   = 8;
    localparam bit MSB = 1'b1;
`ifdef PCLER8_SNAP_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int MASK = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] d = '0;
    logic         ld = 1'b0, clr = 1'b0, en = 1'b0, cin = 1'b0;
    logic [W-1:0] cnt;
    logic         cout;
    logic         req = 1'b0, ack;
    logic         sdo, vld;
    logic         rdy = 1'b0;
    logic         busy;

    int vectors = 0;
    int miscompares = 0;

    int m_cnt = 0;
    bit m_ack = 1'b0;
    bit q[$];

    pcler8_snap_reader #(.CNT_W(W), .MSB_FIRST(1)) dut (
        .clk_pad(clk), .rst_pad(rst), .d_pad(d),
        .ld_pad(ld), .clr_pad(clr), .en_pad(en), .cin_pad(cin),
        .cnt_pad(cnt), .cout_pad(cout),
        .snap_req_pad(req), .snap_ack_pad(ack),
        .sdo_pad(sdo), .sdo_vld_pad(vld), .sdo_rdy_pad(rdy),
        .busy_pad(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_output();
        bit exp_cout;
        bit exp_vld;
        exp_cout = en && cin && !ld && !clr && (m_cnt == MASK);
        exp_vld  = (q.size() > 0);
        chk("cnt", 32'(cnt), 32'(m_cnt));
        chk("cout", 32'(cout), 32'(exp_cout));
        chk("vld", 32'(vld), 32'(exp_vld));
        chk("sdo", 32'(sdo), exp_vld ? 32'(q[0]) : 32'd0);
        chk("ack", 32'(ack), 32'(m_ack));
        chk("busy", 32'(busy), 32'(exp_vld || m_ack));
    endtask

    task automatic model_reset();
        q.delete();
        m_ack = 1'b0;
        m_cnt = 0;
    endtask

    // Frame contents come straight from the snapshot value: data bits in the chosen order, then parity.
    task automatic build_frame(input int snap);
        for (int i = 0; i < W; i++) begin
            if (MSB) q.push_back(bit'((snap >> (W - 1 - i)) & 1));
            else     q.push_back(bit'((snap >> i) & 1));
        end
        if (PAR) q.push_back(bit'($countones(snap) & 1));
    endtask

    task automatic model_edge();
        bit next_ack;
        next_ack = 1'b0;
        if (q.size() > 0) begin
            if (rdy) begin
                void'(q.pop_front());
                if (q.size() == 0) next_ack = 1'b1;
            end
        end else if (!m_ack && req) begin
            build_frame(m_cnt);
        end
        m_ack = next_ack;
        if (ld)            m_cnt = int'(d);
        else if (clr)      m_cnt = 0;
        else if (en && cin) m_cnt = (m_cnt + 1) & MASK;
    endtask

    task automatic tick();
        #3;
        check_output();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [W-1:0] dv, input bit l, input bit c,
                                  input bit e, input bit ci, input bit r, input bit ry);
        d = dv; ld = l; clr = c; en = e; cin = ci; req = r; rdy = ry;
    endtask

    initial begin
        // Asynchronous reset with no clock edge involved.
        #1 rst = 1'b1;
        #2;
        model_reset();
        check_output();
        @(posedge clk);
        #1 rst = 1'b0;

        // Load near the top and count across the wrap.
        apply_stimulus(8'hFE, 1, 0, 1, 1, 0, 1);
        tick();
        apply_stimulus(8'h00, 0, 0, 1, 1, 0, 1);
        repeat (3) tick();

        // Load beats clear and count.
        apply_stimulus(8'h5A, 1, 1, 1, 1, 0, 1);
        tick();
        apply_stimulus(8'h00, 0, 0, 0, 0, 0, 1);
        tick();

        // Frame of 8'hA5 with sink always ready.
        apply_stimulus(8'hA5, 1, 0, 0, 0, 0, 1);
        tick();
        apply_stimulus(8'h00, 0, 0, 0, 0, 1, 1);
        tick();
        req = 1'b0;
        repeat (N_WAIT()) tick();

        // Ready toggling while the counter keeps running and requests arrive mid-frame.
        apply_stimulus(8'hA5, 1, 0, 0, 0, 0, 1);
        tick();
        apply_stimulus(8'h00, 0, 0, 1, 1, 1, 1);
        tick();
        for (int i = 0; i < 2 * W + 6; i++) begin
            rdy = (i % 2 == 0);
            req = (i % 5 == 2);
            tick();
        end
        req = 1'b0; rdy = 1'b1;
        repeat (4) tick();

        // Request held high: ignored in DONE, accepted the cycle after.
        apply_stimulus(8'h07, 1, 0, 0, 0, 0, 1);
        tick();
        ld = 1'b0; req = 1'b1;
        repeat (2 * N_WAIT() + 3) tick();
        req = 1'b0;
        repeat (N_WAIT() + 2) tick();

        // Abort a frame with an asynchronous reset after three bits.
        apply_stimulus(8'h3C, 1, 0, 0, 0, 0, 1);
        tick();
        apply_stimulus(8'h00, 0, 0, 1, 1, 1, 1);
        tick();
        req = 1'b0;
        repeat (3) tick();
        #1 rst = 1'b1;
        #1;
        model_reset();
        check_output();
        @(posedge clk);
        #1 rst = 1'b0;
        apply_stimulus(8'h00, 0, 0, 1, 1, 1, 1);
        tick();
        req = 1'b0;
        repeat (N_WAIT() + 2) tick();

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            d   = W'($urandom);
            ld  = ($urandom_range(0, 15) == 0);
            clr = ($urandom_range(0, 15) == 0);
            en  = ($urandom_range(0, 3) != 0);
            cin = ($urandom_range(0, 3) != 0);
            req = ($urandom_range(0, 5) == 0);
            rdy = ($urandom_range(0, 2) != 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    function automatic int N_WAIT();
        return W + (PAR ? 1 : 0) + 2;
    endfunction

endmodule
